// File: rtl/input_buffer_ctrl.sv
// Sequencer for the 3-row zero-padded line buffer feeding the 3x3 conv engine.
// Streams the padded image out of sync RAM in raster order. The first three rows
// fill the buffer, and each later row is loaded after a shift. Each complete
// window is handed to the conv engine with a start/done handshake.
module input_buffer_ctrl #(
    parameter int unsigned PIXEL_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH      = 18,
    parameter int unsigned ZP_IMAGE_WIDTH  = 482,
    parameter int unsigned ZP_IMAGE_HEIGHT = 362,
    parameter int unsigned BUFFER_WIDTH    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_buf_addr,
    output logic                  o_buf_en,
    output logic                  o_buf_shift,
    output logic                  o_conv_start,
    input  logic                  i_conv_done,
    output logic [8:0]            o_row_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int unsigned ROW_IDX_WIDTH = 9;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FILL       = 3'd1;
    localparam logic [2:0] S_DRAIN      = 3'd2;
    localparam logic [2:0] S_CONV_START = 3'd3;
    localparam logic [2:0] S_CONV_WAIT  = 3'd4;
    localparam logic [2:0] S_SHIFT      = 3'd5;
    localparam logic [2:0] S_LOAD       = 3'd6;
    localparam logic [2:0] S_FINISH     = 3'd7;

    localparam logic [ADDR_WIDTH-1:0]    ROW_STEP = ADDR_WIDTH'(ZP_IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]    FILL_END = ADDR_WIDTH'(BUFFER_WIDTH * ZP_IMAGE_WIDTH - 1);
    localparam logic [ROW_IDX_WIDTH-1:0] LAST_WIN = ROW_IDX_WIDTH'(ZP_IMAGE_HEIGHT - 3);

    // Reject parameter sets the sequencing cannot support
    if (BUFFER_WIDTH != 3 || PIXEL_WIDTH == 0 || ZP_IMAGE_HEIGHT < 3) begin : g_bad_params
        $error("input_buffer_ctrl: unsupported parameter set");
    end

    logic [2:0]               state_q;
    logic [2:0]               state_d;
    logic [ADDR_WIDTH-1:0]    row_end_q;
    logic [ADDR_WIDTH-1:0]    row_end_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_d;
    logic                     rd_en_d;
    logic                     shift_d;
    logic                     conv_start_d;
    logic [ROW_IDX_WIDTH-1:0] row_idx_d;
    logic                     busy_d;
    logic                     done_d;

    // Next-state and next-output decode; outputs are registered below
    always_comb begin
        state_d      = state_q;
        row_end_d    = row_end_q;
        mem_addr_d   = o_mem_addr;
        rd_en_d      = 1'b0;
        row_idx_d    = o_row_idx;
        conv_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_FILL;
                    mem_addr_d = '0;
                    rd_en_d    = 1'b1;
                    row_end_d  = FILL_END;
                    row_idx_d  = '0;
                end
            end
            // Addresses run consecutively across the whole image, so the
            // read address only ever increments; row_end marks the stop point.
            S_FILL, S_LOAD: begin
                if (o_mem_addr == row_end_q) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_addr_d = o_mem_addr + ADDR_WIDTH'(1);
                    rd_en_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_CONV_START;
            end
            // The pulse is registered from this state, landing two cycles after
            // the final buffer write so the window is settled when sampled.
            S_CONV_START: begin
                state_d      = S_CONV_WAIT;
                conv_start_d = 1'b1;
            end
            // A done coincident with the start pulse belongs to no window yet
            S_CONV_WAIT: begin
                if (i_conv_done && !o_conv_start) begin
                    state_d = (o_row_idx == LAST_WIN) ? S_FINISH : S_SHIFT;
                end
            end
            S_SHIFT: begin
                state_d    = S_LOAD;
                mem_addr_d = o_mem_addr + ADDR_WIDTH'(1);
                rd_en_d    = 1'b1;
                row_end_d  = row_end_q + ROW_STEP;
                row_idx_d  = o_row_idx + ROW_IDX_WIDTH'(1);
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        shift_d = (state_d == S_SHIFT);
        done_d  = (state_d == S_FINISH);
        busy_d  = (state_d != S_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= S_IDLE;
            row_end_q    <= '0;
            o_mem_addr   <= '0;
            o_mem_rd_en  <= 1'b0;
            o_buf_addr   <= '0;
            o_buf_en     <= 1'b0;
            o_buf_shift  <= 1'b0;
            o_conv_start <= 1'b0;
            o_row_idx    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_end_q    <= row_end_d;
            o_mem_addr   <= mem_addr_d;
            o_mem_rd_en  <= rd_en_d;
            o_buf_addr   <= o_mem_addr;
            o_buf_en     <= o_mem_rd_en;
            o_buf_shift  <= shift_d;
            o_conv_start <= conv_start_d;
            o_row_idx    <= row_idx_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
        end
    end

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Bench for input_buffer_ctrl: a small 6x5 image instance and a full-width
// 482x6 instance, with a conv-engine model and an address/window scoreboard.
module tb_input_buffer_ctrl;

    localparam int unsigned AW = 18;
    localparam int SW = 6;
    localparam int SH = 5;
    localparam int MW = 482;
    localparam int MH = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic nrst;
    logic start;
    logic conv_done;
    logic sel;

    int vectors = 0;
    int miscompares = 0;

    logic start_s, start_m, cdone_s, cdone_m;
    always_comb begin
        start_s = start && !sel;
        start_m = start && sel;
        cdone_s = conv_done && !sel;
        cdone_m = conv_done && sel;
    end

    logic [AW-1:0] s_addr, s_baddr, w_addr, w_baddr;
    logic s_rd, s_ben, s_shift, s_cs, s_busy, s_done;
    logic w_rd, w_ben, w_shift, w_cs, w_busy, w_done;
    logic [8:0] s_idx, w_idx;

    input_buffer_ctrl #(.ZP_IMAGE_WIDTH(SW), .ZP_IMAGE_HEIGHT(SH)) dut_s (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_s),
        .o_mem_addr(s_addr), .o_mem_rd_en(s_rd), .o_buf_addr(s_baddr), .o_buf_en(s_ben),
        .o_buf_shift(s_shift), .o_conv_start(s_cs), .i_conv_done(cdone_s),
        .o_row_idx(s_idx), .o_busy(s_busy), .o_done(s_done)
    );

    input_buffer_ctrl #(.ZP_IMAGE_WIDTH(MW), .ZP_IMAGE_HEIGHT(MH)) dut_w (
        .i_clk(clk), .i_nrst(nrst), .i_start(start_m),
        .o_mem_addr(w_addr), .o_mem_rd_en(w_rd), .o_buf_addr(w_baddr), .o_buf_en(w_ben),
        .o_buf_shift(w_shift), .o_conv_start(w_cs), .i_conv_done(cdone_m),
        .o_row_idx(w_idx), .o_busy(w_busy), .o_done(w_done)
    );

    logic [AW-1:0] m_addr, m_baddr;
    logic m_rd, m_ben, m_shift, m_cs, m_busy, m_done;
    logic [8:0] m_idx;
    always_comb begin
        if (!sel) begin
            m_addr = s_addr; m_baddr = s_baddr; m_rd = s_rd; m_ben = s_ben; m_shift = s_shift;
            m_cs = s_cs; m_busy = s_busy; m_done = s_done; m_idx = s_idx;
        end else begin
            m_addr = w_addr; m_baddr = w_baddr; m_rd = w_rd; m_ben = w_ben; m_shift = w_shift;
            m_cs = w_cs; m_busy = w_busy; m_done = w_done; m_idx = w_idx;
        end
    end

    logic [2*AW+16:0] all_s, all_w;
    assign all_s = {s_addr, s_rd, s_baddr, s_ben, s_shift, s_cs, s_idx, s_busy, s_done};
    assign all_w = {w_addr, w_rd, w_baddr, w_ben, w_shift, w_cs, w_idx, w_busy, w_done};

    task automatic test_reset();
        nrst = 1'b0; start = 1'b1; conv_done = 1'b0; sel = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b0;
        nrst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if (all_s !== '0 || all_w !== '0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: small=%h wide=%h required 0", i, all_s, all_w);
            end
        end
    endtask

    // One complete run on the selected instance with a scoreboard of every
    // expected read address and window index. The conv model answers
    // 'delay' cycles after each start; abuse adds stray dones and starts.
    task automatic run_case(input int w, input int h, input int delay, input bit abuse, input string tag);
        int exp_addr_q[$];
        int exp_idx_q[$];
        int start_cyc, done_at, acc_done, last_ben, ben_row, n_cs, n_shift, n_done, k, e;
        bit prev_rd, first_rd, finished, coinc;
        logic [AW-1:0] prev_addr;

        for (int a = 0; a < w * h; a++) exp_addr_q.push_back(a);
        for (int r = 0; r <= h - 3; r++) exp_idx_q.push_back(r);
        done_at = -1; acc_done = -100; last_ben = -100; ben_row = 0;
        n_cs = 0; n_shift = 0; n_done = 0;
        prev_rd = 1'b0; prev_addr = '0; first_rd = 1'b1; finished = 1'b0;

        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        for (int n = 0; n < 20000 && !finished; n++) begin
            @(negedge clk);
            k = cyc;
            coinc = 1'b0;
            vectors++;
            if (m_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b required 1", tag, k, m_busy);
            end
            vectors++;
            if (m_ben !== prev_rd || (prev_rd && m_baddr !== prev_addr)) begin
                miscompares++;
                $display("FAIL %s buf_delay cycle %0d: en=%b addr=%0d required en=%b addr=%0d",
                         tag, k, m_ben, m_baddr, prev_rd, prev_addr);
            end
            if (m_ben && m_shift) begin
                vectors++; miscompares++;
                $display("FAIL %s en_shift_overlap cycle %0d: both 1 required exclusive", tag, k);
            end
            if (m_rd) begin
                if (first_rd) begin
                    vectors++;
                    if (k !== start_cyc + 1) begin
                        miscompares++;
                        $display("FAIL %s first_read cycle %0d required %0d", tag, k, start_cyc + 1);
                    end
                    first_rd = 1'b0;
                end
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_read addr %0d required none", tag, m_addr);
                end else begin
                    e = exp_addr_q.pop_front();
                    if (m_addr !== AW'(e)) begin
                        miscompares++;
                        $display("FAIL %s read_addr cycle %0d: got %0d required %0d", tag, k, m_addr, e);
                    end
                end
            end
            if (m_ben) begin
                ben_row++;
                last_ben = k;
            end
            if (m_cs) begin
                vectors++;
                if (exp_idx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_conv_start row_idx %0d required none", tag, m_idx);
                end else begin
                    e = exp_idx_q.pop_front();
                    if (m_idx !== 9'(e)) begin
                        miscompares++;
                        $display("FAIL %s row_idx: got %0d required %0d", tag, m_idx, e);
                    end
                end
                vectors++;
                if (ben_row !== ((n_cs == 0) ? 3 * w : w)) begin
                    miscompares++;
                    $display("FAIL %s row_buf_en_count: got %0d required %0d", tag, ben_row,
                             (n_cs == 0) ? 3 * w : w);
                end
                if (n_cs == 0) begin
                    vectors++;
                    if (k - last_ben !== 2) begin
                        miscompares++;
                        $display("FAIL %s start_after_fill: got %0d cycles required 2", tag, k - last_ben);
                    end
                end
                n_cs++;
                ben_row = 0;
                done_at = k + delay;
                coinc = 1'b1;
            end
            if (m_shift) begin
                n_shift++;
                vectors++;
                if (k !== acc_done + 1) begin
                    miscompares++;
                    $display("FAIL %s shift_timing cycle %0d required %0d", tag, k, acc_done + 1);
                end
            end
            if (m_done) begin
                n_done++;
                vectors++;
                if (k !== acc_done + 1) begin
                    miscompares++;
                    $display("FAIL %s done_timing cycle %0d required %0d", tag, k, acc_done + 1);
                end
                finished = 1'b1;
            end
            // inputs for the next edge
            start = abuse && (n >= 20 && n <= 22);
            conv_done = 1'b0;
            if (k == done_at) begin
                conv_done = 1'b1;
                acc_done = k;
            end
            if (abuse && (coinc || k == start_cyc + 5)) conv_done = 1'b1;
            prev_rd = m_rd;
            prev_addr = m_addr;
        end
        start = 1'b0;
        conv_done = 1'b0;

        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: no done pulse required one", tag);
        end
        vectors++;
        if (n_cs !== h - 2 || n_shift !== h - 3 || n_done !== 1) begin
            miscompares++;
            $display("FAIL %s counts: starts=%0d shifts=%0d dones=%0d required %0d %0d 1",
                     tag, n_cs, n_shift, n_done, h - 2, h - 3);
        end
        vectors++;
        if (exp_addr_q.size() != 0 || exp_idx_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s leftover: reads=%0d windows=%0d required 0 0",
                     tag, exp_addr_q.size(), exp_idx_q.size());
        end
        @(negedge clk);
        vectors++;
        if (m_busy !== 1'b0 || m_done !== 1'b0 || m_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL %s post_run: busy=%b done=%b rd=%b required 0 0 0", tag, m_busy, m_done, m_rd);
        end
    endtask

    task automatic test_fill();
        sel = 1'b0;
        run_case(SW, SH, 4, 1'b0, "fill");
    endtask

    task automatic test_full_run();
        sel = 1'b0;
        run_case(SW, SH, 7, 1'b0, "full");
    endtask

    task automatic test_handshake_abuse();
        sel = 1'b0;
        run_case(SW, SH, 3, 1'b1, "abuse");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_case(SW, SH, 1, 1'b0, "b2b_a");
        run_case(SW, SH, 1, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid_load();
        int done_at;
        bit hit;
        sel = 1'b1;
        done_at = -1;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 5000 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            conv_done = (cyc == done_at);
            if (m_cs) done_at = cyc + 4;
            if (m_rd && m_addr == AW'(2000)) hit = 1'b1;
        end
        conv_done = 1'b0;
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reset_mid_load timeout: addr 2000 never read");
        end
        nrst = 1'b0;
        #1;
        vectors++;
        if (all_w !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_load async_clear: got %h required 0", all_w);
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (all_w !== '0) begin
                miscompares++;
                $display("FAIL reset_mid_load no_resume: got %h required 0", all_w);
            end
        end
    endtask

    task automatic test_wide_run();
        sel = 1'b1;
        run_case(MW, MH, 5, 1'b0, "wide");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_run();
        test_handshake_abuse();
        test_back_to_back();
        test_reset_mid_load();
        test_wide_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
